counter_gate_ctrl: RTL and testbench

COUNTER_GATE_CTRL -- requirements
Module: counter_gate_ctrl

---
 rtl/counter_gate_ctrl.sv | 130 +++++++++++++
 tb/tb_counter_gate_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/counter_gate_ctrl.sv
// Gated event counter controller: counts synchronized rising edges of evt during
// a programmable gate window and hands the result over with a valid/ack handshake.
module counter_gate_ctrl #(
  parameter int unsigned WIDTH  = 30,
  parameter int unsigned GATE_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              evt,
  output logic              gate,
  output logic              busy,
  output logic [WIDTH-1:0]  result,
  output logic              ovf,
  output logic              res_valid,
  input  logic              res_ack
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_GATE,
    S_DONE
  } state_e;

  localparam logic [WIDTH-1:0] COUNT_MAX = '1;

  state_e              state_q;
  logic [GATE_W-1:0]   timer_q;
  logic [WIDTH-1:0]    count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                gate_q, busy_q, res_valid_q;
  logic [WIDTH-1:0]    result_q;
  logic                sync1_q, sync2_q, sync3_q;
  logic                evt_edge;
  logic [GATE_W-1:0]   gate_len_eff;

  // NOTE: sync1/sync2 form the metastability synchronizer; sync3 only delays
  // sync2 so the rising edge can be detected on clean, already-synchronized data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= evt;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign evt_edge     = sync2_q & ~sync3_q;
  assign gate_len_eff = (gate_len == '0) ? GATE_W'(1) : gate_len;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (evt_edge) begin
      if (count_q == COUNT_MAX) ovf_d   = 1'b1;
      else                      count_d = count_q + WIDTH'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      gate_q      <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      result_q    <= '0;
    end else if (abort) begin
      // Abort outranks start, ack and gate expiry; result keeps the last value.
      state_q     <= S_IDLE;
      gate_q      <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_ARM;
            busy_q  <= 1'b1;
          end
        end
        S_ARM: begin
          count_q <= '0;
          ovf_q   <= 1'b0;
          timer_q <= gate_len_eff;
          gate_q  <= 1'b1;
          state_q <= S_GATE;
        end
        S_GATE: begin
          count_q <= count_d;
          ovf_q   <= ovf_d;
          timer_q <= timer_q - GATE_W'(1);
          if (timer_q == GATE_W'(1)) begin
            // Latch count_d so an edge on the final gate cycle is included.
            result_q    <= count_d;
            res_valid_q <= 1'b1;
            gate_q      <= 1'b0;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (res_ack && res_valid_q) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gate      = gate_q;
  assign busy      = busy_q;
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign res_valid = res_valid_q;

endmodule

// File: tb/tb_counter_gate_ctrl.sv
// Directed bench for counter_gate_ctrl: default-width instance plus a WIDTH=4
// instance sharing the same stimulus for saturation checks.
module tb_counter_gate_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [23:0] gate_len;
  logic        evt;
  logic        res_ack;

  logic        gate, busy, ovf, res_valid;
  logic [29:0] result;
  logic        gate_n, busy_n, ovf_n, res_valid_n;
  logic [3:0]  result_n;

  int checks = 0;
  int errors = 0;

  counter_gate_ctrl #(.WIDTH(30), .GATE_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gate_len(gate_len),
    .evt(evt), .gate(gate), .busy(busy), .result(result), .ovf(ovf),
    .res_valid(res_valid), .res_ack(res_ack)
  );

  counter_gate_ctrl #(.WIDTH(4), .GATE_W(24)) dut_n (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gate_len(gate_len),
    .evt(evt), .gate(gate_n), .busy(busy_n), .result(result_n), .ovf(ovf_n),
    .res_valid(res_valid_n), .res_ack(res_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Start a measurement and run ncyc cycles after ARM. evt is pulsed for one
  // cycle at loop indices first, first+step, ... <= last; gate samples counted.
  task automatic measure(input int len, input int ncyc, input int first, input int last,
                         input int step, input bit hold_start, output int gate_cnt);
    gate_len = 24'(len);
    start = 1'b1;
    @(posedge clk); #1;
    start = hold_start;
    gate_cnt = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      if (gate) gate_cnt++;
      evt = (i >= first && i <= last && ((i - first) % step) == 0);
    end
    evt = 1'b0;
    start = 1'b0;
  endtask

  task automatic do_ack();
    res_ack = 1'b1;
    @(posedge clk); #1;
    res_ack = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({gate, busy, res_valid, ovf, result} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got gate=%b busy=%b vld=%b ovf=%b result=%0d, expected all 0",
               gate, busy, res_valid, ovf, result);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int gc;
    measure(100, 110, 2, 38, 4, 1'b0, gc);
    checks++;
    if (gc !== 100) begin errors++; $display("FAIL basic_gate_cycles: got %0d expected 100", gc); end
    checks++;
    if ({res_valid, busy, ovf} !== 3'b110) begin
      errors++; $display("FAIL basic_flags: got vld/busy/ovf=%b expected 110", {res_valid, busy, ovf});
    end
    checks++;
    if (result !== 30'd10) begin errors++; $display("FAIL basic_result: got %0d expected 10", result); end
    do_ack();
    checks++;
    if ({res_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL basic_ack: got vld/busy=%b expected 00", {res_valid, busy});
    end
  endtask

  task automatic test_zero_len();
    int gc;
    gate_len = '0;
    evt = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    gc = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (gate) gc++;
    end
    checks++;
    if (gc !== 1) begin errors++; $display("FAIL zero_len_gate_cycles: got %0d expected 1", gc); end
    checks++;
    if (res_valid !== 1'b1 || result > 30'd1) begin
      errors++; $display("FAIL zero_len_result: got vld=%b result=%0d expected vld=1 result<=1", res_valid, result);
    end
    do_ack();
    checks++;
    if ({res_valid, busy, gate} !== 3'b000) begin
      errors++; $display("FAIL zero_len_idle: got vld/busy/gate=%b expected 000", {res_valid, busy, gate});
    end
    evt = 1'b0;
  endtask

  task automatic test_back_to_back();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart: got busy=%b expected 1", busy); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if ({busy, gate} !== 2'b00) begin
      errors++; $display("FAIL b2b_abort_arm: got busy/gate=%b expected 00", {busy, gate});
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_overflow();
    int gc;
    measure(50, 60, 2, 40, 2, 1'b0, gc);
    checks++;
    if (result_n !== 4'd15 || ovf_n !== 1'b1) begin
      errors++; $display("FAIL ovf_narrow: got result=%0d ovf=%b expected 15/1", result_n, ovf_n);
    end
    checks++;
    if (result !== 30'd20 || ovf !== 1'b0) begin
      errors++; $display("FAIL ovf_wide: got result=%0d ovf=%b expected 20/0", result, ovf);
    end
    do_ack();
  endtask

  task automatic test_abort_done();
    int gc;
    measure(20, 30, 2, 6, 4, 1'b1, gc);
    checks++;
    if (gc !== 20) begin errors++; $display("FAIL start_in_gate: got %0d gate cycles expected 20", gc); end
    checks++;
    if ({res_valid, busy} !== 2'b11 || result !== 30'd2) begin
      errors++; $display("FAIL abort_pre: got vld/busy=%b result=%0d expected 11/2", {res_valid, busy}, result);
    end
    abort = 1'b1;
    res_ack = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    res_ack = 1'b0;
    checks++;
    if ({res_valid, busy, gate} !== 3'b000 || result !== 30'd2) begin
      errors++;
      $display("FAIL abort_done: got vld/busy/gate=%b result=%0d expected 000/2", {res_valid, busy, gate}, result);
    end
  endtask

  task automatic test_reset_mid_gate();
    int gc;
    measure(100, 35, 2, 26, 4, 1'b0, gc);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gate, busy, res_valid, ovf, result} !== '0) begin
      errors++;
      $display("FAIL reset_mid_gate: got gate=%b busy=%b vld=%b ovf=%b result=%0d expected all 0",
               gate, busy, res_valid, ovf, result);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    measure(20, 24, 2, 10, 4, 1'b0, gc);
    checks++;
    if (result !== 30'd3 || res_valid !== 1'b1) begin
      errors++; $display("FAIL post_reset_measure: got result=%0d vld=%b expected 3/1", result, res_valid);
    end
    do_ack();
  endtask

  task automatic test_last_cycle_edge();
    int gc;
    measure(10, 14, 7, 7, 1, 1'b0, gc);
    checks++;
    if (result !== 30'd1) begin errors++; $display("FAIL edge_last_cycle: got %0d expected 1", result); end
    do_ack();
    measure(10, 14, 8, 8, 1, 1'b0, gc);
    checks++;
    if (result !== 30'd0) begin errors++; $display("FAIL edge_after_gate: got %0d expected 0", result); end
    do_ack();
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    gate_len = '0;
    evt      = 1'b0;
    res_ack  = 1'b0;

    test_reset();
    test_basic();
    test_zero_len();
    test_back_to_back();
    test_overflow();
    test_abort_done();
    test_reset_mid_gate();
    test_last_cycle_edge();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
